// File: rtl/meter_rst_pkg.sv
// Shared encodings for the meter PLL lock supervisor and reset sequencer.
package meter_rst_pkg;

  typedef enum logic [2:0] {
    PLLRST = 3'd0,
    WAIT   = 3'd1,
    STABLE = 3'd2,
    HOLD   = 3'd3,
    RUN    = 3'd4
  } state_e;

  localparam int unsigned LOST_CNT_W = 8;

endpackage

// File: rtl/meter_sync_ff.sv
// Generic reset-to-0 multi-flop bit synchronizer.
module meter_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/meter_pll_rst_seq.sv
// PLL lock supervisor: drives PLL reset with retries, gates the meter-domain
// reset on stable lock, and records lock losses seen while running.
module meter_pll_rst_seq
  import meter_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 32,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned RST_HOLD_CYCLES     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  input  logic                  lost_clr,
  output logic                  pll_rst,
  output logic                  meter_rst_n,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOST_CNT_W-1:0] lost_cnt,
  output logic [2:0]            state
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CD  = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  logic lock_s;

  meter_sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pll_rst_q, pll_rst_d;
  logic                    meter_rst_n_q, meter_rst_n_d;
  logic                    ready_q, ready_d;
  logic                    lock_lost_q, lock_lost_d;
  logic [LOST_CNT_W-1:0]   lost_cnt_q, lost_cnt_d, lost_base;
  logic                    loss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLLRST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PLLRST: if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = WAIT;
      WAIT: begin
        if (lock_s)                                        state_d = STABLE;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) state_d = PLLRST;
      end
      STABLE: begin
        if (!lock_s)                                      state_d = WAIT;
        else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_s)                                   state_d = WAIT;
        else if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) state_d = RUN;
      end
      RUN:     if (!lock_s) state_d = WAIT;
      default: state_d = PLLRST;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  // Clear is applied before a coincident loss, so clear+loss leaves a count of 1.
  always_comb begin
    pll_rst_d     = (state_d == PLLRST);
    meter_rst_n_d = (state_d == RUN);
    ready_d       = (state_d == RUN);
    loss          = (state_q == RUN) && !lock_s;
    lost_base     = lost_clr ? '0 : lost_cnt_q;
    lock_lost_d   = lost_clr ? 1'b0 : lock_lost_q;
    lost_cnt_d    = lost_base;
    if (loss) begin
      lock_lost_d = 1'b1;
      if (lost_base != '1) lost_cnt_d = lost_base + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q     <= 1'b1;
      meter_rst_n_q <= 1'b0;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
      lost_cnt_q    <= '0;
    end else begin
      pll_rst_q     <= pll_rst_d;
      meter_rst_n_q <= meter_rst_n_d;
      ready_q       <= ready_d;
      lock_lost_q   <= lock_lost_d;
      lost_cnt_q    <= lost_cnt_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign meter_rst_n = meter_rst_n_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign lost_cnt    = lost_cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_meter_pll_rst_seq.sv
// Bench for meter_pll_rst_seq: directed phases plus random lock activity,
// checked every cycle against a phase/elapsed-time reference model.
module tb_meter_pll_rst_seq;

  localparam int unsigned T_RST = 4, T_TO = 64, T_ST = 8, T_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b1;
  logic       lost_clr = 1'b0;
  logic       pll_rst, meter_rst_n, ready, lock_lost;
  logic [7:0] lost_cnt;
  logic [2:0] state;

  meter_pll_rst_seq #(
    .SYNC_STAGES         (2),
    .PLL_RST_CYCLES      (T_RST),
    .LOCK_TIMEOUT_CYCLES (T_TO),
    .LOCK_STABLE_CYCLES  (T_ST),
    .RST_HOLD_CYCLES     (T_HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .lost_clr    (lost_clr),
    .pll_rst     (pll_rst),
    .meter_rst_n (meter_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .lost_cnt    (lost_cnt),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: phase number, cycles elapsed in phase, lock history.
  int m_ph, m_age, m_lost, m_cnt;
  bit s1, s2;
  int dur [5] = '{T_RST, T_TO, T_ST, T_HOLD, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ph = 0; m_age = 0; m_lost = 0; m_cnt = 0; s1 = 0; s2 = 0;
  endtask

  task automatic model_edge(input bit v, input bit clr);
    bit ls;
    int np;
    ls = s2; s2 = s1; s1 = v;
    np = m_ph;
    if (m_ph >= 1 && m_ph != 1 && !ls) np = 1;          // any lock drop after WAIT falls back to WAIT
    else if (m_ph == 1 && ls) np = 2;
    else if (m_ph != 4 && m_age + 1 == dur[m_ph]) np = (m_ph == 1) ? 0 : m_ph + 1;
    if (clr) begin m_lost = 0; m_cnt = 0; end
    if (m_ph == 4 && !ls) begin
      m_lost = 1;
      if (m_cnt < 255) m_cnt++;
    end
    m_age = (np != m_ph) ? 0 : m_age + 1;
    m_ph = np;
  endtask

  task automatic check_all();
    check("state", 32'(state), 32'(m_ph));
    check("pll_rst", 32'(pll_rst), 32'(m_ph == 0));
    check("meter_rst_n", 32'(meter_rst_n), 32'(m_ph == 4));
    check("ready", 32'(ready), 32'(m_ph == 4));
    check("lock_lost", 32'(lock_lost), 32'(m_lost));
    check("lost_cnt", 32'(lost_cnt), 32'(m_cnt));
  endtask

  task automatic step(input bit v, input bit clr);
    pll_lock = v;
    lost_clr = clr;
    @(posedge clk);
    model_edge(v, clr);
    #1;
    lost_clr = 1'b0;
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    check({tag, "_meter_rst_n"}, 32'(meter_rst_n), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
    check({tag, "_lost_cnt"}, 32'(lost_cnt), 32'd0);
  endtask

  // Release reset with lock held and count edges until meter_rst_n rises.
  task automatic startup_latency(input string tag);
    int n, hi;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; hi = 0;
    while (meter_rst_n !== 1'b1 && n < 200) begin
      step(1'b1, 1'b0);
      n++;
      if (pll_rst === 1'b1) hi++;
    end
    check({tag, "_latency"}, 32'(n), 32'd17);
    check({tag, "_pll_rst_edges"}, 32'(hi), 32'(T_RST - 1));
    check({tag, "_state_run"}, 32'(state), 32'd4);
  endtask

  task automatic run_until(input int ph, input int age);
    int n = 0;
    while (!(m_ph == ph && m_age == age) && n < 300) begin
      step(1'b1, 1'b0);
      n++;
    end
    check("reach_phase", 32'(m_ph), 32'(ph));
  endtask

  initial begin
    int n;
    bit v;
    int pct;
    model_reset();

    // 1: reset values, then startup with lock tied high
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("t1_reset");
    startup_latency("t1");

    // 2: lock held low -> periodic PLL retries, no losses counted beyond the first drop
    pll_lock = 1'b0;
    repeat (2 * (T_RST + T_TO) + 20) step(1'b0, 1'b0);
    check("t2_no_meter", 32'(meter_rst_n), 32'd0);

    // 3: one-cycle drop while counting stable lock
    run_until(2, 5);
    step(1'b0, 1'b0);
    n = 1;
    while (meter_rst_n !== 1'b1 && n < 200) begin
      step(1'b1, 1'b0);
      n++;
    end
    check("t3_latency", 32'(n), 32'd16);
    check("t3_lost_cnt", 32'(lost_cnt), 32'd1);

    // 4: loss in RUN
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("t4_still_run", 32'(state), 32'd4);
    step(1'b0, 1'b0);
    check("t4_state", 32'(state), 32'd1);
    check("t4_lock_lost", 32'(lock_lost), 32'd1);
    check("t4_lost_cnt", 32'(lost_cnt), 32'd2);
    run_until(4, 0);

    // 5: saturate the loss counter, then clear coincident with a loss
    for (int k = 0; k < 256; k++) begin
      run_until(4, 0);
      repeat (3) step(1'b0, 1'b0);
    end
    check("t5_saturated", 32'(lost_cnt), 32'd255);
    run_until(4, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("t5_clr_loss_cnt", 32'(lost_cnt), 32'd1);
    check("t5_clr_loss_flag", 32'(lock_lost), 32'd1);
    step(1'b0, 1'b1);
    check("t5_clr_only", 32'(lost_cnt), 32'd0);

    // random lock activity with occasional clears
    for (int seg = 0; seg < 15; seg++) begin
      pct = $urandom_range(60, 100);
      for (int k = 0; k < 200; k++) begin
        v = ($urandom_range(0, 99) < pct);
        step(v, ($urandom_range(0, 49) == 0));
      end
    end

    // 6: asynchronous reset in HOLD, then full restart
    run_until(3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals("t6_held");
    startup_latency("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
